// File: rtl/nco_pkg.sv
// nco_pkg: definitions shared by the NCO controller blocks.
//   - sweep mode encodings carried on cfg_mode
//   - sweep FSM state enum (also exported on the dbg_state debug port)
//   - is_single(): decodes the mode field; the unused code 2'b11 acts as single
`timescale 1ns/1ps
package nco_pkg;

  localparam logic [1:0] MODE_SINGLE   = 2'b00;
  localparam logic [1:0] MODE_REPEAT   = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN_UP = 2'd2,
    ST_RUN_DN = 2'd3
  } sweep_state_t;

  function automatic logic is_single(input logic [1:0] mode);
    return !((mode == MODE_REPEAT) || (mode == MODE_PINGPONG));
  endfunction

endpackage

// File: rtl/nco_dwell_timer.sv
// nco_dwell_timer: down-counter that sets how long each phase increment is held.
//   clk, rst : clock, asynchronous active-high reset (count -> 0)
//   load     : load count with value (takes priority over counting)
//   en       : count down; on reaching 0 the count reloads from value
//   value    : load / reload value (hold time is value+1 cycles)
//   count    : current count
//   expire   : high in the enabled cycle where count is 0
`timescale 1ns/1ps
module nco_dwell_timer #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          en,
  input  logic [DW-1:0] value,
  output logic [DW-1:0] count,
  output logic          expire
);

  assign expire = en && !load && (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en) begin
      if (count == '0) count <= value;
      else             count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: steps an NCO phase increment from start to stop in
// increments of step, holding each value dwell+1 cycles. Modes: single,
// repeat, ping-pong.
//
// Handshake: a configuration transfers on a rising clk edge where
// cfg_valid & cfg_ready are both 1; cfg_ready is 1 only while idle, and the
// offer may be held or dropped freely by the source.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cfg_valid / cfg_ready    configuration handshake
//   cfg_start/stop/step      phase increment range and step (unsigned, PW bits)
//   cfg_dwell                hold count per value (DW bits)
//   cfg_mode                 00 single, 01 repeat, 10 ping-pong, 11 single
//   go, abort                level-sampled start / stop requests
//   phase_inc                registered increment for the NCO
//   nco_rst                  one-cycle pulse while the sweep is loading
//   busy, done, seg_tick     status: running, single sweep finished, value changed
//   dbg_state                current FSM state (sweep_state_t encoding)
`timescale 1ns/1ps
module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int PW = 32,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [PW-1:0] cfg_start,
  input  logic [PW-1:0] cfg_stop,
  input  logic [PW-1:0] cfg_step,
  input  logic [DW-1:0] cfg_dwell,
  input  logic [1:0]    cfg_mode,
  input  logic          go,
  input  logic          abort,
  output logic [PW-1:0] phase_inc,
  output logic          nco_rst,
  output logic          busy,
  output logic          done,
  output logic          seg_tick,
  output logic [1:0]    dbg_state
);

  sweep_state_t state, state_d;

  // Shadow config (written by the handshake) and active config (copied from
  // the shadow when a sweep starts, so a config accepted on the go cycle
  // only affects the next sweep).
  logic [PW-1:0] sh_start, sh_stop, sh_step;
  logic [DW-1:0] sh_dwell;
  logic [1:0]    sh_mode;
  logic [PW-1:0] act_start, act_stop, act_step;
  logic [DW-1:0] act_dwell;
  logic [1:0]    act_mode;

  logic [PW-1:0] phase_d;
  logic          nco_rst_d, done_d, seg_tick_d;

  logic          go_accept, cfg_take, degen, step_fire;
  logic          tmr_expire;
  logic [DW-1:0] tmr_value, tmr_count;

  logic          up_at_stop, dn_at_start, span_le_step;
  logic [PW-1:0] up_nxt, dn_nxt, turn_up_nxt, turn_dn_nxt;

  assign dbg_state = state;
  assign go_accept = (state == ST_IDLE) && go && !abort;
  assign cfg_take  = cfg_valid && cfg_ready;

  // Zero step or an empty range: hold start until aborted.
  assign degen     = (act_step == '0) || (act_start >= act_stop);
  assign step_fire = (state != ST_IDLE) && tmr_expire && !degen && !abort;

  // Step arithmetic. Distances are compared before adding/subtracting, so
  // an intermediate result can never wrap past the range ends.
  assign up_at_stop   = (phase_inc == act_stop);
  assign up_nxt       = ((act_stop - phase_inc) <= act_step) ? act_stop : phase_inc + act_step;
  assign dn_at_start  = (phase_inc == act_start);
  assign dn_nxt       = ((phase_inc - act_start) <= act_step) ? act_start : phase_inc - act_step;
  assign span_le_step = ((act_stop - act_start) <= act_step);
  assign turn_up_nxt  = span_le_step ? act_stop  : act_start + act_step;
  assign turn_dn_nxt  = span_le_step ? act_start : act_stop - act_step;

  // The timer runs from LOAD onward; a go loads it from the shadow dwell
  // because the active copy is being written on that same edge.
  assign tmr_value = (state == ST_IDLE) ? sh_dwell : act_dwell;

  nco_dwell_timer #(.DW(DW)) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .load   (go_accept),
    .en     (state != ST_IDLE),
    .value  (tmr_value),
    .count  (tmr_count),
    .expire (tmr_expire)
  );

  // Config registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_start  <= '0;
      sh_stop   <= '0;
      sh_step   <= '0;
      sh_dwell  <= '0;
      sh_mode   <= MODE_SINGLE;
      act_start <= '0;
      act_stop  <= '0;
      act_step  <= '0;
      act_dwell <= '0;
      act_mode  <= MODE_SINGLE;
    end else begin
      if (cfg_take) begin
        sh_start <= cfg_start;
        sh_stop  <= cfg_stop;
        sh_step  <= cfg_step;
        sh_dwell <= cfg_dwell;
        sh_mode  <= cfg_mode;
      end
      if (go_accept) begin
        act_start <= sh_start;
        act_stop  <= sh_stop;
        act_step  <= sh_step;
        act_dwell <= sh_dwell;
        act_mode  <= sh_mode;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Next-state logic. LOAD shares the up-step path: with dwell 0 the first
  // step already happens at the end of the LOAD cycle.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (go_accept) state_d = ST_LOAD;
      end
      ST_LOAD, ST_RUN_UP: begin
        state_d = ST_RUN_UP;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (step_fire && up_at_stop) begin
          if (is_single(act_mode))           state_d = ST_IDLE;
          else if (act_mode == MODE_PINGPONG) state_d = ST_RUN_DN;
          else                                state_d = ST_RUN_UP;
        end
      end
      ST_RUN_DN: begin
        if (abort)                          state_d = ST_IDLE;
        else if (step_fire && dn_at_start)  state_d = ST_RUN_UP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    phase_d    = phase_inc;
    nco_rst_d  = 1'b0;
    done_d     = 1'b0;
    seg_tick_d = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go_accept) begin
          phase_d   = sh_start;
          nco_rst_d = 1'b1;
        end
      end
      ST_LOAD, ST_RUN_UP: begin
        if (step_fire) begin
          if (up_at_stop) begin
            if (is_single(act_mode))            done_d  = 1'b1;
            else if (act_mode == MODE_PINGPONG) phase_d = turn_dn_nxt;
            else                                phase_d = act_start;
          end else begin
            phase_d = up_nxt;
          end
        end
      end
      ST_RUN_DN: begin
        if (step_fire) phase_d = dn_at_start ? turn_up_nxt : dn_nxt;
      end
      default: ;
    endcase
    // Only a step may flag a change; the LOAD entry never does.
    if (step_fire && (phase_d != phase_inc)) seg_tick_d = 1'b1;
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_inc <= '0;
      nco_rst   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      seg_tick  <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      phase_inc <= phase_d;
      nco_rst   <= nco_rst_d;
      busy      <= (state_d != ST_IDLE);
      done      <= done_d;
      seg_tick  <= seg_tick_d;
      cfg_ready <= (state_d == ST_IDLE);
    end
  end

  // The count itself is only observed through expire.
  logic unused_count;
  assign unused_count = ^tmr_count;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb_nco_sweep_ctrl: directed bench for nco_sweep_ctrl (PW=32, DW=16).
`timescale 1ns/1ps
module tb_nco_sweep_ctrl;

  localparam int PW = 32;
  localparam int DW = 16;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [PW-1:0] cfg_start = '0;
  logic [PW-1:0] cfg_stop  = '0;
  logic [PW-1:0] cfg_step  = '0;
  logic [DW-1:0] cfg_dwell = '0;
  logic [1:0]    cfg_mode  = '0;
  logic          go    = 1'b0;
  logic          abort = 1'b0;
  logic [PW-1:0] phase_inc;
  logic          nco_rst, busy, done, seg_tick;
  logic [1:0]    dbg_state;

  nco_sweep_ctrl #(.PW(PW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_start (cfg_start),
    .cfg_stop  (cfg_stop),
    .cfg_step  (cfg_step),
    .cfg_dwell (cfg_dwell),
    .cfg_mode  (cfg_mode),
    .go        (go),
    .abort     (abort),
    .phase_inc (phase_inc),
    .nco_rst   (nco_rst),
    .busy      (busy),
    .done      (done),
    .seg_tick  (seg_tick),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle; everything is driven and sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [PW-1:0] s, input logic [PW-1:0] e,
                         input logic [PW-1:0] st, input logic [DW-1:0] d,
                         input logic [1:0] m);
    cfg_start = s; cfg_stop = e; cfg_step = st; cfg_dwell = d; cfg_mode = m;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic start_sweep();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  logic [31:0] pp_exp  [8] = '{32'd0, 32'd10, 32'd20, 32'd10, 32'd0, 32'd10, 32'd20, 32'd10};
  logic [31:0] rep_exp [7] = '{32'd0, 32'd10, 32'd20, 32'd0, 32'd10, 32'd20, 32'd0};
  logic [31:0] clp_exp [4] = '{32'd0, 32'd10, 32'd20, 32'd25};

  initial begin
    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("rst_phase", phase_inc, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_seg", {31'd0, seg_tick}, 0);
    check("rst_nco_rst", {31'd0, nco_rst}, 0);
    check("rst_cfg_ready", {31'd0, cfg_ready}, 1);
    check("rst_state", {30'd0, dbg_state}, 0);
    rst = 1'b0;
    tick();

    // Single sweep 100 -> 130 step 10 dwell 2, with go held while busy
    set_cfg(100, 130, 10, 2, 2'b00);
    start_sweep();
    check("ss_c1_phase", phase_inc, 100);
    check("ss_c1_nco_rst", {31'd0, nco_rst}, 1);
    check("ss_c1_busy", {31'd0, busy}, 1);
    check("ss_c1_seg", {31'd0, seg_tick}, 0);
    check("ss_c1_cfg_ready", {31'd0, cfg_ready}, 0);
    for (int c = 2; c <= 13; c++) begin
      tick();
      if (c <= 12) begin
        check($sformatf("ss_c%0d_phase", c), phase_inc, 100 + 10 * ((c - 1) / 3));
        check($sformatf("ss_c%0d_seg", c), {31'd0, seg_tick}, (c == 4 || c == 7 || c == 10) ? 1 : 0);
        check($sformatf("ss_c%0d_busy", c), {31'd0, busy}, 1);
        check($sformatf("ss_c%0d_done", c), {31'd0, done}, 0);
        check($sformatf("ss_c%0d_nco_rst", c), {31'd0, nco_rst}, 0);
      end else begin
        check("ss_end_phase", phase_inc, 130);
        check("ss_end_done", {31'd0, done}, 1);
        check("ss_end_busy", {31'd0, busy}, 0);
        check("ss_end_seg", {31'd0, seg_tick}, 0);
      end
      if (c == 5) go = 1'b1;
      if (c == 7) go = 1'b0;
    end
    tick();
    check("ss_after_done", {31'd0, done}, 0);
    check("ss_after_cfg_ready", {31'd0, cfg_ready}, 1);
    check("ss_after_phase", phase_inc, 130);

    // Abort during the 120 hold
    start_sweep();
    for (int c = 2; c <= 7; c++) tick();
    check("ab_c7_phase", phase_inc, 120);
    do_abort();
    check("ab_busy", {31'd0, busy}, 0);
    check("ab_phase", phase_inc, 120);
    check("ab_done", {31'd0, done}, 0);
    check("ab_cfg_ready", {31'd0, cfg_ready}, 1);
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("ab_hold%0d_done", c), {31'd0, done}, 0);
      check($sformatf("ab_hold%0d_phase", c), phase_inc, 120);
    end

    // Clamp at stop: 0, 10, 20, 25, done
    set_cfg(0, 25, 10, 0, 2'b00);
    start_sweep();
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) tick();
      check($sformatf("cl_c%0d_phase", c), phase_inc, clp_exp[c-1]);
      check($sformatf("cl_c%0d_done", c), {31'd0, done}, 0);
    end
    tick();
    check("cl_end_done", {31'd0, done}, 1);
    check("cl_end_busy", {31'd0, busy}, 0);
    check("cl_end_phase", phase_inc, 25);
    tick();

    // Config handshake in the go cycle: this sweep uses the old config
    cfg_start = 500; cfg_stop = 600; cfg_step = 50; cfg_dwell = 0; cfg_mode = 2'b00;
    cfg_valid = 1'b1;
    go = 1'b1;
    tick();
    cfg_valid = 1'b0;
    go = 1'b0;
    check("cg_c1_phase", phase_inc, 0);
    check("cg_c1_nco_rst", {31'd0, nco_rst}, 1);
    tick();
    check("cg_c2_phase", phase_inc, 10);
    do_abort();
    check("cg_abort_phase", phase_inc, 10);
    start_sweep();
    check("cg_new_phase", phase_inc, 500);
    do_abort();
    check("cg_new_abort_phase", phase_inc, 500);
    check("cg_new_abort_busy", {31'd0, busy}, 0);

    // go and abort together in idle
    go = 1'b1; abort = 1'b1;
    tick();
    go = 1'b0; abort = 1'b0;
    check("ga_busy", {31'd0, busy}, 0);
    check("ga_nco_rst", {31'd0, nco_rst}, 0);
    check("ga_state", {30'd0, dbg_state}, 0);
    check("ga_phase", phase_inc, 500);

    // Ping-pong 0..20 step 10
    set_cfg(0, 20, 10, 0, 2'b10);
    start_sweep();
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) tick();
      check($sformatf("pp_c%0d_phase", c), phase_inc, pp_exp[c-1]);
      check($sformatf("pp_c%0d_seg", c), {31'd0, seg_tick}, (c > 1) ? 1 : 0);
      check($sformatf("pp_c%0d_busy", c), {31'd0, busy}, 1);
    end
    do_abort();
    check("pp_abort_busy", {31'd0, busy}, 0);
    check("pp_abort_done", {31'd0, done}, 0);

    // Repeat 0..20 step 10
    set_cfg(0, 20, 10, 0, 2'b01);
    start_sweep();
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) tick();
      check($sformatf("rp_c%0d_phase", c), phase_inc, rep_exp[c-1]);
      check($sformatf("rp_c%0d_done", c), {31'd0, done}, 0);
      check($sformatf("rp_c%0d_busy", c), {31'd0, busy}, 1);
    end
    do_abort();

    // Mode 11 behaves as single
    set_cfg(0, 20, 10, 0, 2'b11);
    start_sweep();
    tick(); tick();
    check("m3_c3_phase", phase_inc, 20);
    tick();
    check("m3_done", {31'd0, done}, 1);
    check("m3_busy", {31'd0, busy}, 0);
    tick();

    // Degenerate: step 0 holds start until abort
    set_cfg(50, 20, 0, 0, 2'b00);
    start_sweep();
    check("dg_c1_phase", phase_inc, 50);
    for (int c = 2; c <= 8; c++) begin
      tick();
      check($sformatf("dg_c%0d_phase", c), phase_inc, 50);
      check($sformatf("dg_c%0d_seg", c), {31'd0, seg_tick}, 0);
      check($sformatf("dg_c%0d_busy", c), {31'd0, busy}, 1);
    end
    do_abort();
    check("dg_abort_busy", {31'd0, busy}, 0);
    check("dg_abort_phase", phase_inc, 50);

    // Reset mid-sweep: outputs clear at once, config returns to zero
    set_cfg(100, 130, 10, 2, 2'b00);
    start_sweep();
    for (int c = 2; c <= 5; c++) tick();
    check("mr_pre_phase", phase_inc, 110);
    rst = 1'b1;
    #1;
    check("mr_phase", phase_inc, 0);
    check("mr_busy", {31'd0, busy}, 0);
    check("mr_done", {31'd0, done}, 0);
    check("mr_seg", {31'd0, seg_tick}, 0);
    check("mr_cfg_ready", {31'd0, cfg_ready}, 1);
    check("mr_state", {30'd0, dbg_state}, 0);
    tick();
    check("mr_hold_done", {31'd0, done}, 0);
    rst = 1'b0;
    tick();
    start_sweep();
    check("mr_go_phase", phase_inc, 0);
    check("mr_go_busy", {31'd0, busy}, 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("mr_zero%0d_phase", c), phase_inc, 0);
      check($sformatf("mr_zero%0d_seg", c), {31'd0, seg_tick}, 0);
    end
    do_abort();
    check("mr_abort_busy", {31'd0, busy}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
